// File: rtl/weight_ram_pkg.sv
// rtl/weight_ram_pkg.sv - shared types and helpers for the banked weight store
// Parity storage is compiled in when WEIGHT_RAM_PARITY_EN is defined.
package weight_ram_pkg;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } ram_state_t;

`ifdef WEIGHT_RAM_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

  function automatic int row_w(input int addr_w, input int banks);
    return addr_w - clog2(banks);
  endfunction

  function automatic logic even_parity(input logic [31:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/weight_ram_bank.sv
// rtl/weight_ram_bank.sv - one weight bank: single write port, registered read port
// Collisions on the same row return the incoming write data (write-first).
module weight_ram_bank
  import weight_ram_pkg::*;
#(
  parameter int WORD_W = 2,
  parameter int DEPTH  = 256,
  parameter int ROW_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we_i,
  input  logic [ROW_W-1:0]  waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ROW_W-1:0]  raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // The array itself is deliberately not reset; the sweep FSM clears it.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/weight_ram_banked.sv
// rtl/weight_ram_banked.sv - banked ternary-weight store with row-wide reads and clear sweep
// Define WEIGHT_RAM_PARITY_EN to store and check a per-word even-parity bit.
module weight_ram_banked
  import weight_ram_pkg::*;
#(
  parameter int DATA_WIDTH = 2,
  parameter int ADDR_WIDTH = 10,
  parameter int NUM_NEURON = 1024,
  parameter int NUM_BANKS  = 4,
  localparam int ROW_W     = row_w(ADDR_WIDTH, NUM_BANKS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            init_start,
  output logic                            init_busy,
  input  logic                            we,
  input  logic [ADDR_WIDTH-1:0]           ain,
  input  logic [DATA_WIDTH-1:0]           din,
  input  logic                            wr_inject,
  input  logic                            re,
  input  logic [ROW_W-1:0]                aout,
  output logic                            rvalid,
  output logic [NUM_BANKS*DATA_WIDTH-1:0] dout,
  output logic [NUM_BANKS-1:0]            rd_perr
);

  localparam int NUM_ROWS = NUM_NEURON / NUM_BANKS;
  localparam int WORD_W   = DATA_WIDTH + PAR_W;
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS - 1);

  ram_state_t        state_q, state_d;
  logic [ROW_W-1:0]  cnt_q, cnt_d;
  logic              rvalid_q, oor_q;

  logic              clearing, idle;
  logic [31:0]       ain_ext, wr_lane;
  logic [ROW_W-1:0]  wr_row;
  logic              wr_ok, rd_oor, rd_go;
  logic [WORD_W-1:0] wr_word;
  logic [WORD_W-1:0] bank_rdata [NUM_BANKS];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_ROW) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end
      ST_IDLE: begin
        if (init_start) begin
          state_d = ST_CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_CLEAR;
    endcase
  end

  assign clearing  = (state_q == ST_CLEAR);
  assign idle      = (state_q == ST_IDLE);
  assign init_busy = clearing;

  // Power-of-two divide/modulo reduce to the row/bank bit fields of ain.
  assign ain_ext = 32'(ain);
  assign wr_lane = ain_ext % 32'(NUM_BANKS);
  assign wr_row  = ROW_W'(ain_ext / 32'(NUM_BANKS));
  assign wr_ok   = we && idle && (ain_ext < 32'(NUM_NEURON));
  assign rd_oor  = 32'(aout) >= 32'(NUM_ROWS);
  assign rd_go   = re && idle && !rd_oor;

`ifdef WEIGHT_RAM_PARITY_EN
  assign wr_word = {even_parity(32'(din)) ^ wr_inject, din};
`else
  logic unused_wr_inject;
  assign unused_wr_inject = wr_inject;
  assign wr_word          = din;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rvalid_q <= 1'b0;
      oor_q    <= 1'b0;
    end else begin
      rvalid_q <= re && idle;
      if (re && idle) oor_q <= rd_oor;
    end
  end

  assign rvalid = rvalid_q;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    logic bank_we;
    assign bank_we = clearing || (wr_ok && (wr_lane == 32'(b)));

    weight_ram_bank #(
      .WORD_W (WORD_W),
      .DEPTH  (NUM_ROWS),
      .ROW_W  (ROW_W)
    ) u_bank (
      .clk     (clk),
      .rst     (reset),
      .we_i    (bank_we),
      .waddr_i (clearing ? cnt_q : wr_row),
      .wdata_i (clearing ? '0 : wr_word),
      .re_i    (rd_go),
      .raddr_i (aout),
      .rdata_o (bank_rdata[b])
    );

    assign dout[b*DATA_WIDTH +: DATA_WIDTH] = oor_q ? '0 : bank_rdata[b][DATA_WIDTH-1:0];

`ifdef WEIGHT_RAM_PARITY_EN
    // Stored word includes its parity bit, so a clean word has even overall parity.
    assign rd_perr[b] = !oor_q && even_parity(32'(bank_rdata[b]));
`endif
  end

`ifndef WEIGHT_RAM_PARITY_EN
  assign rd_perr = '0;
`endif

endmodule

// File: tb/tb_weight_ram_banked.sv
// tb/tb_weight_ram_banked.sv - directed self-checking bench for weight_ram_banked
// Expected rd_perr for the injected-parity vector follows WEIGHT_RAM_PARITY_EN.
module tb_weight_ram_banked;

  logic       clk = 1'b0;
  logic       reset, init_start, init_busy, we, wr_inject, re, rvalid;
  logic [9:0] ain;
  logic [1:0] din;
  logic [7:0] aout;
  logic [7:0] dout;
  logic [3:0] rd_perr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  weight_ram_banked dut (
    .clk        (clk),
    .reset      (reset),
    .init_start (init_start),
    .init_busy  (init_busy),
    .we         (we),
    .ain        (ain),
    .din        (din),
    .wr_inject  (wr_inject),
    .re         (re),
    .aout       (aout),
    .rvalid     (rvalid),
    .dout       (dout),
    .rd_perr    (rd_perr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] a, input logic [1:0] d, input logic inj);
    we = 1'b1; ain = a; din = d; wr_inject = inj;
    tick;
    we = 1'b0; wr_inject = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a);
    re = 1'b1; aout = a;
    tick;
    re = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (init_busy && n < 1000) begin
      tick;
      n++;
    end
  endtask

  int n;
  int rv_seen;

  initial begin
    reset = 1'b0; init_start = 1'b0; we = 1'b0; wr_inject = 1'b0; re = 1'b0;
    ain = '0; din = '0; aout = '0;
    #1 reset = 1'b1;
    #2;
    chk("rst_busy", init_busy, 1);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_perr", rd_perr, 0);
    tick; tick;
    reset = 1'b0;
    busy_len(n);
    chk("init_len", n, 256);

    for (int r = 0; r < 256; r++) begin
      rd(8'(r));
      chk("clr_rvalid", rvalid, 1);
      chk("clr_row", dout, 0);
    end
    tick;
    chk("idle_rvalid", rvalid, 0);

    wr(10'd5, 2'b01, 1'b0);
    wr(10'd6, 2'b11, 1'b0);
    rd(8'd1);
    chk("row1_valid", rvalid, 1);
    chk("row1_data", dout, 8'h34);
    tick;
    chk("hold_rvalid", rvalid, 0);
    chk("hold_dout", dout, 8'h34);

    we = 1'b1; ain = 10'd8; din = 2'b10; re = 1'b1; aout = 8'd2;
    tick;
    we = 1'b0; re = 1'b0;
    chk("bypass_row2", dout, 8'h02);
    rd(8'd2);
    chk("stored_row2", dout, 8'h02);

    wr(10'd12, 2'b01, 1'b0);
    rd(8'd3);
    chk("row3_pre", dout, 8'h01);
    init_start = 1'b1;
    tick;
    init_start = 1'b0;
    chk("sweep_busy", init_busy, 1);
    we = 1'b1; ain = 10'd13; din = 2'b11; re = 1'b1; aout = 8'd3;
    n = 0; rv_seen = 0;
    while (init_busy && n < 1000) begin
      init_start = (n == 50);
      tick;
      n++;
      if (rvalid) rv_seen++;
    end
    we = 1'b0; re = 1'b0; init_start = 1'b0;
    chk("sweep_len", n, 256);
    chk("sweep_rvalid", rv_seen, 0);
    chk("sweep_dout_hold", dout, 8'h01);
    rd(8'd3);
    chk("row3_post", dout, 8'h00);

    wr(10'd9, 2'b11, 1'b0);
    re = 1'b1; aout = 8'd2; init_start = 1'b1;
    tick;
    re = 1'b0; init_start = 1'b0;
    chk("row2_w9", dout, 8'h0C);
    chk("row2_valid", rvalid, 1);
    for (int i = 0; i < 100; i++) tick;
    chk("mid_busy", init_busy, 1);
    #2 reset = 1'b1;
    #1;
    chk("async_dout", dout, 0);
    chk("async_busy", init_busy, 1);
    chk("async_rvalid", rvalid, 0);
    tick; tick;
    reset = 1'b0;
    busy_len(n);
    chk("restart_len", n, 256);
    rd(8'd2);
    chk("row2_cleared", dout, 8'h00);

    wr(10'd16, 2'b11, 1'b0);
    wr(10'd17, 2'b01, 1'b1);
    rd(8'd4);
    chk("row4_data", dout, 8'h07);
`ifdef WEIGHT_RAM_PARITY_EN
    chk("row4_perr", rd_perr, 4'b0010);
`else
    chk("row4_perr", rd_perr, 4'b0000);
`endif
    rd(8'd1);
    chk("row1_perr", rd_perr, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/weight_ram_banked.md
Name: weight_ram_banked

Overview:
Banked ternary-weight store for the annealing core.
- Replaces a per-word combinational-read RAM.
- One word is written per cycle.
- One full row of NUM_BANKS consecutive words is read per cycle, registered, with a valid flag.
- Contents are cleared by an internal sweep FSM after reset or on request. The array is not reset-cleared.

Parameters:
DATA_WIDTH, 2, bits per weight (ternary encoding)
ADDR_WIDTH, 10, word address width
NUM_NEURON, 1024, number of words; must be a multiple of NUM_BANKS and at most 2**ADDR_WIDTH
NUM_BANKS, 4, parallel read lanes; power of two, at least 1

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
init_start  in  1  pulse; starts a clear sweep when idle
init_busy  out  1  high while the clear sweep runs
we  in  1  write enable
ain  in  ADDR_WIDTH  write word address
din  in  DATA_WIDTH  write data
wr_inject  in  1  flips the stored parity bit of this write (active only with the feature)
re  in  1  read enable
aout  in  ROW_W  read row address; ROW_W = ADDR_WIDTH - log2(NUM_BANKS)
rvalid  out  1  dout valid
dout  out  NUM_BANKS*DATA_WIDTH  lane b holds word aout*NUM_BANKS+b in bits [b*DATA_WIDTH +: DATA_WIDTH]
rd_perr  out  NUM_BANKS  per-lane parity error, qualified by rvalid

Behaviour:
- Write address decode:
  - bank = ain[log2(NUM_BANKS)-1:0]
  - row = ain[ADDR_WIDTH-1:log2(NUM_BANKS)]
- Reset (asynchronous):
  - FSM enters CLEAR with row counter at 0.
  - init_busy=1, rvalid=0, dout=0, rd_perr=0.
- FSM states:
  - CLEAR: writes 0 (and correct parity) to row cnt in all banks each cycle.
  - CLEAR exits to IDLE after row NUM_NEURON/NUM_BANKS-1 is written. init_busy drops on the cycle IDLE is entered.
  - IDLE: init_start=1 returns to CLEAR with cnt=0. init_start is ignored in CLEAR (no restart).
- Sweep timing: a sweep lasts exactly NUM_NEURON/NUM_BANKS cycles.
- Reset asserted mid-sweep: the sweep restarts from row 0 after reset release.
- During CLEAR:
  - we and re are ignored.
  - rvalid=0.
  - dout holds its last value.
- Write (IDLE):
  - we=1 with ain < NUM_NEURON: the word is stored at the clock edge.
  - ain >= NUM_NEURON: the write is silently dropped.
- Read (IDLE):
  - re=1: rvalid=1 and dout = row contents on the next cycle (latency 1).
  - re=0: rvalid=0 next cycle and dout holds.
  - Row out of range: dout=0 and rvalid=1.
- Read/write collision: same row in the same cycle is write-first. The written lane returns new din; other lanes return stored data.
- Back-to-back reads every cycle are supported (full throughput).

Optional Feature:
Macro WEIGHT_RAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit over its data; wr_inject=1 inverts that bit.
  - On read, rd_perr[b]=1 when lane b's parity mismatches; registered alongside dout.
  - The clear sweep writes correct parity.
  - The collision bypass forwards the injected parity state too.
- Undefined:
  - No parity storage; wr_inject is ignored; rd_perr is constant 0.
  - Ports are identical in both builds.

Decomposition:
- Package weight_ram_pkg:
  - clog2 function
  - ROW_W derivation helper
  - FSM state encoding ST_CLEAR/ST_IDLE
  - even-parity function
- Sub-module weight_ram_bank: one bank with one write port and one synchronous read port, parity bit stored when the feature is enabled.
- The top level holds the FSM, decode, bypass and output registers, instantiating NUM_BANKS banks.

Test Plan:
- Reset, release, hold idle -> init_busy=1 for exactly 256 cycles (defaults); then re with aout=0..255 -> every row reads 0, rvalid=1 one cycle after each re.
- After init: write ain=5 din=2'b01, ain=6 din=2'b11; read aout=1 -> dout lane1=01, lane2=11, lanes0/3=00.
- Same-cycle we ain=8 din=2'b10 with re aout=2 -> next cycle lane0=10 (write-first); a later read of aout=2 gives the same value.
- Write ain=12 din=01; pulse init_start; issue we/re during sweep -> rvalid stays 0, writes dropped; after 256 cycles aout=3 reads all zeros.
- Assert reset at sweep cycle 100 for 2 cycles -> outputs reset immediately, without waiting for a clock edge; sweep restarts and init_busy lasts 256 cycles after release.
- With WEIGHT_RAM_PARITY_EN: write ain=17 din=01 wr_inject=1, read aout=4 -> rd_perr=4'b0010; without the macro, same stimulus gives rd_perr=0.
